// File: rtl/taxi_pkg.sv
// taxi_pkg: shared types and geometry constants for the taxi game
package taxi_pkg;
  localparam int CW = 10;
  localparam int HIT_RADIUS = 8;
  localparam int TW = 11;
  typedef enum logic [2:0] {WAIT, CARRY_P1, CARRY_P2, COOLDOWN} fare_state_t;
endpackage

// File: rtl/fare_tracker_box_hit.sv
// box_hit: strict square-box overlap test between two unsigned screen points
module box_hit #(
  parameter int CW = 10,
  parameter int HIT_RADIUS = 8
) (
  input  logic [CW-1:0] ax,
  input  logic [CW-1:0] ay,
  input  logic [CW-1:0] bx,
  input  logic [CW-1:0] by,
  output logic          hit
);
  localparam logic [CW:0] R = (CW+1)'(HIT_RADIUS);
  logic signed [CW:0] w_dx, w_dy;
  logic [CW:0] w_mx, w_my;
  assign w_dx = $signed({1'b0, ax}) - $signed({1'b0, bx});
  assign w_dy = $signed({1'b0, ay}) - $signed({1'b0, by});
  assign w_mx = w_dx[CW] ? -w_dx : w_dx;
  assign w_my = w_dy[CW] ? -w_dy : w_dy;
  assign hit = (w_mx < R) && (w_my < R);
endmodule

// File: rtl/fare_tracker.sv
// fare_tracker: passenger lifecycle FSM producing per-player delivery increment pulses
module fare_tracker import taxi_pkg::*; #(
  parameter int COOLDOWN_FRAMES = 60,
  parameter int FARE_TIMEOUT = 1800
) (
  input  logic          FrameClk,
  input  logic          Reset_n,
  input  logic          DrawGame,
  input  logic [CW-1:0] P1_x,
  input  logic [CW-1:0] P1_y,
  input  logic [CW-1:0] P2_x,
  input  logic [CW-1:0] P2_y,
  input  logic [CW-1:0] Pickup_x,
  input  logic [CW-1:0] Pickup_y,
  input  logic [CW-1:0] Dropoff_x,
  input  logic [CW-1:0] Dropoff_y,
  output logic          Increment_p1,
  output logic          Increment_p2,
  output logic          P1_carrying,
  output logic          P2_carrying,
  output logic          Passenger_vis,
  output logic          NewFare,
  output logic [TW-1:0] Timer
);
  localparam logic [TW-1:0] TO = TW'(FARE_TIMEOUT);
  localparam logic [TW-1:0] CD = TW'(COOLDOWN_FRAMES - 1);
  fare_state_t r_state, w_nxt;
  logic [TW-1:0] r_timer, w_timer, r_cool, w_cool;
  logic r_tie, w_tie, w_inc1, w_inc2, w_nf;
  logic r_inc1, r_inc2, r_nf, r_c1, r_c2, r_vis;
  logic w_h1p, w_h2p, w_h1d, w_h2d;
  box_hit #(.CW(CW), .HIT_RADIUS(HIT_RADIUS)) u_h1p (.ax(P1_x), .ay(P1_y), .bx(Pickup_x), .by(Pickup_y), .hit(w_h1p));
  box_hit #(.CW(CW), .HIT_RADIUS(HIT_RADIUS)) u_h2p (.ax(P2_x), .ay(P2_y), .bx(Pickup_x), .by(Pickup_y), .hit(w_h2p));
  box_hit #(.CW(CW), .HIT_RADIUS(HIT_RADIUS)) u_h1d (.ax(P1_x), .ay(P1_y), .bx(Dropoff_x), .by(Dropoff_y), .hit(w_h1d));
  box_hit #(.CW(CW), .HIT_RADIUS(HIT_RADIUS)) u_h2d (.ax(P2_x), .ay(P2_y), .bx(Dropoff_x), .by(Dropoff_y), .hit(w_h2d));
  // next state: pickup arbitration, delivery beats timeout, cooldown countdown, DrawGame clear
  always_comb begin
    w_nxt = r_state;
    w_timer = r_timer;
    w_cool = r_cool;
    w_tie = r_tie;
    w_inc1 = 1'b0;
    w_inc2 = 1'b0;
    w_nf = 1'b0;
    case (r_state)
      WAIT: if (w_h1p || w_h2p) begin
        w_nxt = (w_h1p && w_h2p) ? (r_tie ? CARRY_P2 : CARRY_P1) : (w_h1p ? CARRY_P1 : CARRY_P2);
        w_tie = r_tie ^ (w_h1p && w_h2p);
        w_timer = TO;
      end
      CARRY_P1, CARRY_P2: begin
        w_inc1 = (r_state == CARRY_P1) && w_h1d;
        w_inc2 = (r_state == CARRY_P2) && w_h2d;
        w_timer = (w_inc1 || w_inc2) ? '0 : r_timer - 1'b1;
        if (w_inc1 || w_inc2 || r_timer == TW'(1)) begin
          w_nxt = COOLDOWN;
          w_cool = CD;
        end
      end
      COOLDOWN: begin
        w_nf = (r_cool == '0);
        w_nxt = w_nf ? WAIT : COOLDOWN;
        w_cool = w_nf ? '0 : r_cool - 1'b1;
      end
      default: w_nxt = WAIT;
    endcase
    if (!DrawGame) begin
      w_nxt = WAIT;
      w_timer = '0;
      w_cool = '0;
      w_tie = 1'b0;
      w_inc1 = 1'b0;
      w_inc2 = 1'b0;
      w_nf = 1'b0;
    end
  end
  // state and registered outputs; flags decode the upcoming state so they align with it
  always_ff @(posedge FrameClk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= WAIT;
      r_timer <= '0;
      r_cool <= '0;
      r_tie <= 1'b0;
      r_inc1 <= 1'b0;
      r_inc2 <= 1'b0;
      r_nf <= 1'b0;
      r_c1 <= 1'b0;
      r_c2 <= 1'b0;
      r_vis <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_timer <= w_timer;
      r_cool <= w_cool;
      r_tie <= w_tie;
      r_inc1 <= w_inc1;
      r_inc2 <= w_inc2;
      r_nf <= w_nf;
      r_c1 <= (w_nxt == CARRY_P1);
      r_c2 <= (w_nxt == CARRY_P2);
      r_vis <= DrawGame && (w_nxt == WAIT);
    end
  end
  assign Increment_p1 = r_inc1;
  assign Increment_p2 = r_inc2;
  assign P1_carrying = r_c1;
  assign P2_carrying = r_c2;
  assign Passenger_vis = r_vis;
  assign NewFare = r_nf;
  assign Timer = r_timer;
endmodule
